// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt claim controller: register map,
// CTRL field positions, and the bus/claim state encodings.
package intc_pkg;

  localparam logic [2:0] ADDR_ENABLE    = 3'd0;
  localparam logic [2:0] ADDR_MASK      = 3'd1;
  localparam logic [2:0] ADDR_PRIORITY  = 3'd2;
  localparam logic [2:0] ADDR_CTRL      = 3'd3;
  localparam logic [2:0] ADDR_CLAIM     = 3'd4;
  localparam logic [2:0] ADDR_COMPLETE  = 3'd5;
  localparam logic [2:0] ADDR_INSERVICE = 3'd6;

  localparam int CTRL_MODE_BIT = 0;
  localparam int CTRL_POL_BIT  = 1;
  localparam int CTRL_PW_LSB   = 2;

  typedef enum logic {
    BUS_IDLE,
    BUS_ACK
  } bus_state_e;

  typedef enum logic {
    CLAIM_FREE,
    CLAIM_CLAIMED
  } claim_state_e;

endpackage

// File: rtl/intc_claim_tracker.sv
// Claim/complete handshake: latched vector, in-service bit, sticky error and
// timeout flags. Define INTC_CLAIM_TIMEOUT_EN to compile in the claim timeout.
module intc_claim_tracker
  import intc_pkg::*;
#(
  parameter int N             = 8,
  parameter int CLAIM_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 claim_rd_i,
  input  logic                 complete_wr_i,
  input  logic [$clog2(N)-1:0] complete_vec_i,
  input  logic                 inservice_rd_i,
  input  logic                 irq_pending_i,
  input  logic [$clog2(N)-1:0] irq_vector_i,
  output logic [31:0]          claim_rdata_o,
  output logic [N-1:0]         in_service_o,
  output logic                 err_o,
  output logic                 timeout_o,
  output logic [N-1:0]         int_clear_o,
  output logic                 claim_active_o
);

  localparam logic [N-1:0] ONE = 1;

  claim_state_e         state_q, state_d;
  logic [$clog2(N)-1:0] vec_q, vec_d;
  logic                 err_q, err_d;
  logic                 to_q, to_d;
  logic [N-1:0]         clear_q, clear_d;
  logic                 complete_ok;
  logic                 timeout_hit;

  assign complete_ok = complete_wr_i && (state_q == CLAIM_CLAIMED) && (complete_vec_i == vec_q);

`ifdef INTC_CLAIM_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // The pulse lands CLAIM_TIMEOUT cycles after entry, so fire on the last count.
  assign timeout_hit = (state_q == CLAIM_CLAIMED) && (cnt_q == 16'(CLAIM_TIMEOUT - 1));
  assign cnt_d       = (state_q == CLAIM_CLAIMED) ? cnt_q + 16'd1 : 16'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(CLAIM_TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d       = state_q;
    vec_d         = vec_q;
    err_d         = err_q;
    to_d          = to_q;
    clear_d       = '0;
    claim_rdata_o = '0;
    if (inservice_rd_i) begin
      err_d = 1'b0;
      to_d  = 1'b0;
    end
    case (state_q)
      CLAIM_FREE: begin
        if (claim_rd_i && irq_pending_i) begin
          claim_rdata_o = {1'b1, 31'(irq_vector_i)};
          vec_d         = irq_vector_i;
          state_d       = CLAIM_CLAIMED;
        end
        if (complete_wr_i) err_d = 1'b1;
      end
      CLAIM_CLAIMED: begin
        if (complete_ok) begin
          clear_d = ONE << vec_q;
          state_d = CLAIM_FREE;
        end else begin
          if (complete_wr_i) err_d = 1'b1;
          if (timeout_hit) begin
            clear_d = ONE << vec_q;
            to_d    = 1'b1;
            state_d = CLAIM_FREE;
          end
        end
      end
      default: state_d = CLAIM_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= CLAIM_FREE;
      vec_q   <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      clear_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      to_q    <= to_d;
      clear_q <= clear_d;
    end
  end

  assign in_service_o   = (state_q == CLAIM_CLAIMED) ? (ONE << vec_q) : '0;
  assign claim_active_o = (state_q == CLAIM_CLAIMED);
  assign err_o          = err_q;
  assign timeout_o      = to_q;
  assign int_clear_o    = clear_q;

endmodule

// File: rtl/intc_claim_ctrl.sv
// Register front-end of the interrupt claim controller: two-state bus
// handshake, configuration registers and the claim tracker instance.
module intc_claim_ctrl
  import intc_pkg::*;
#(
  parameter int N             = 8,
  parameter int P             = 3,
  parameter int W             = 8,
  parameter int CLAIM_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bus_req,
  input  logic                 bus_we,
  input  logic [2:0]           bus_addr,
  input  logic [31:0]          bus_wdata,
  output logic                 bus_ack,
  output logic [31:0]          bus_rdata,
  input  logic                 irq_pending,
  input  logic [$clog2(N)-1:0] irq_vector,
  output logic [N-1:0]         int_enable,
  output logic [N-1:0]         int_mask,
  output logic [N*P-1:0]       int_priority,
  output logic [N-1:0]         int_clear,
  output logic                 out_mode,
  output logic                 out_polarity,
  output logic [W-1:0]         pulse_width,
  output logic                 claim_active
);

  bus_state_e   bus_state_q, bus_state_d;
  logic [N-1:0] enable_q, enable_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N*P-1:0] prio_q, prio_d;
  logic         mode_q, mode_d;
  logic         pol_q, pol_d;
  logic [W-1:0] pw_q, pw_d;
  logic [31:0]  rdata_q, rdata_d;

  logic         access, wr, rd;
  logic [31:0]  claim_rdata;
  logic [N-1:0] in_service;
  logic         err, timeout;
  logic         unused_wdata;

  assign access       = (bus_state_q == BUS_IDLE) && bus_req;
  assign wr           = access && bus_we;
  assign rd           = access && !bus_we;
  assign unused_wdata = ^bus_wdata;

  intc_claim_tracker #(
    .N             (N),
    .CLAIM_TIMEOUT (CLAIM_TIMEOUT)
  ) u_tracker (
    .clk            (clk),
    .rst            (rst),
    .claim_rd_i     (rd && (bus_addr == ADDR_CLAIM)),
    .complete_wr_i  (wr && (bus_addr == ADDR_COMPLETE)),
    .complete_vec_i (bus_wdata[$clog2(N)-1:0]),
    .inservice_rd_i (rd && (bus_addr == ADDR_INSERVICE)),
    .irq_pending_i  (irq_pending),
    .irq_vector_i   (irq_vector),
    .claim_rdata_o  (claim_rdata),
    .in_service_o   (in_service),
    .err_o          (err),
    .timeout_o      (timeout),
    .int_clear_o    (int_clear),
    .claim_active_o (claim_active)
  );

  always_comb begin
    bus_state_d = access ? BUS_ACK : BUS_IDLE;
    enable_d    = enable_q;
    mask_d      = mask_q;
    prio_d      = prio_q;
    mode_d      = mode_q;
    pol_d       = pol_q;
    pw_d        = pw_q;
    rdata_d     = '0;
    if (wr) begin
      case (bus_addr)
        ADDR_ENABLE:   enable_d = bus_wdata[N-1:0];
        ADDR_MASK:     mask_d   = bus_wdata[N-1:0];
        ADDR_PRIORITY: prio_d   = bus_wdata[N*P-1:0];
        ADDR_CTRL: begin
          mode_d = bus_wdata[CTRL_MODE_BIT];
          pol_d  = bus_wdata[CTRL_POL_BIT];
          pw_d   = bus_wdata[CTRL_PW_LSB +: W];
        end
        default: ;
      endcase
    end
    // Read data is captured on the request edge and is zero outside the ACK cycle.
    if (rd) begin
      case (bus_addr)
        ADDR_ENABLE:   rdata_d = 32'(enable_q);
        ADDR_MASK:     rdata_d = 32'(mask_q);
        ADDR_PRIORITY: rdata_d = 32'(prio_q);
        ADDR_CTRL:     rdata_d = 32'({pw_q, pol_q, mode_q});
        ADDR_CLAIM:    rdata_d = claim_rdata;
        ADDR_INSERVICE: begin
          rdata_d     = 32'(in_service);
          rdata_d[31] = err;
          rdata_d[30] = timeout;
        end
        default:       rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_state_q <= BUS_IDLE;
      enable_q    <= '0;
      mask_q      <= '1;
      prio_q      <= '0;
      mode_q      <= 1'b0;
      pol_q       <= 1'b1;
      pw_q        <= '0;
      rdata_q     <= '0;
    end else begin
      bus_state_q <= bus_state_d;
      enable_q    <= enable_d;
      mask_q      <= mask_d;
      prio_q      <= prio_d;
      mode_q      <= mode_d;
      pol_q       <= pol_d;
      pw_q        <= pw_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus_ack      = (bus_state_q == BUS_ACK);
  assign bus_rdata    = rdata_q;
  assign int_enable   = enable_q;
  assign int_mask     = mask_q | in_service;
  assign int_priority = prio_q;
  assign out_mode     = mode_q;
  assign out_polarity = pol_q;
  assign pulse_width  = pw_q;

endmodule

// File: tb/tb_intc_claim_ctrl.sv
// Bench for intc_claim_ctrl: directed vector table, hand-written claim/timeout/
// reset sequences, and random accesses against a register-level reference model.
module tb_intc_claim_ctrl;
  import intc_pkg::*;

  localparam int N  = 8;
  localparam int P  = 3;
  localparam int W  = 8;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         bus_req, bus_we;
  logic [2:0]   bus_addr;
  logic [31:0]  bus_wdata;
  logic         bus_ack;
  logic [31:0]  bus_rdata;
  logic         irq_pending;
  logic [2:0]   irq_vector;
  logic [N-1:0] int_enable, int_mask, int_clear;
  logic [N*P-1:0] int_priority;
  logic         out_mode, out_polarity;
  logic [W-1:0] pulse_width;
  logic         claim_active;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  intc_claim_ctrl #(.N(N), .P(P), .W(W), .CLAIM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .irq_pending(irq_pending), .irq_vector(irq_vector),
    .int_enable(int_enable), .int_mask(int_mask), .int_priority(int_priority),
    .int_clear(int_clear), .out_mode(out_mode), .out_polarity(out_polarity),
    .pulse_width(pulse_width), .claim_active(claim_active)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus access; returns in the ACK cycle (at its falling edge) with the
  // id of the clock edge that sampled the request.
  task automatic access(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                        output int unsigned edge_id, output logic [31:0] rdata);
    @(negedge clk);
    check("ack_idle", bus_ack, 0);
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    @(posedge clk);
    edge_id = cyc;
    @(negedge clk);
    check("ack_next", bus_ack, 1);
    rdata   = bus_rdata;
    bus_req = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        pend;
    logic [2:0]  vec;
    logic [31:0] rdata;
    logic [7:0]  en;
    logic [7:0]  mask;
    logic [23:0] prio;
    logic [7:0]  clr;
    logic        act;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                     input logic pend, input logic [2:0] vec, input logic [31:0] rdata,
                     input logic [7:0] en, input logic [7:0] mask, input logic [23:0] prio,
                     input logic [7:0] clr, input logic act);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.pend = pend; v.vec = vec;
    v.rdata = rdata; v.en = en; v.mask = mask; v.prio = prio; v.clr = clr; v.act = act;
    tbl.push_back(v);
  endtask

  // Reference model state: registers as the programmer sees them.
  logic [7:0]  m_en, m_mask, m_pw;
  logic [23:0] m_prio;
  logic        m_pol, m_mode, m_claimed, m_err, m_to;
  logic [2:0]  m_vec;
  int unsigned m_claim_edge;

  task automatic model_reset();
    m_en = 0; m_mask = 8'hFF; m_prio = 0; m_pw = 0; m_pol = 1; m_mode = 0;
    m_claimed = 0; m_err = 0; m_to = 0; m_vec = 0; m_claim_edge = 0;
  endtask

  task automatic model_step(input int unsigned e, input logic we, input logic [2:0] a,
                            input logic [31:0] wd, input logic pend, input logic [2:0] vec,
                            output logic [31:0] exp_rd, output logic [7:0] exp_clr);
    exp_rd = 0; exp_clr = 0;
`ifdef INTC_CLAIM_TIMEOUT_EN
    if (m_claimed && e > m_claim_edge + TO) begin
      m_claimed = 0; m_to = 1;
    end
`endif
    if (!we) begin
      case (a)
        3'd0: exp_rd = {24'h0, m_en};
        3'd1: exp_rd = {24'h0, m_mask};
        3'd2: exp_rd = {8'h0, m_prio};
        3'd3: exp_rd = {22'h0, m_pw, m_pol, m_mode};
        3'd4: if (!m_claimed && pend) begin
          exp_rd = 32'h8000_0000 | 32'(vec);
          m_claimed = 1; m_vec = vec; m_claim_edge = e;
        end
        3'd6: begin
          exp_rd = {m_err, m_to, 22'h0, m_claimed ? (8'h1 << m_vec) : 8'h0};
          m_err = 0; m_to = 0;
        end
        default: exp_rd = 0;
      endcase
    end else begin
      case (a)
        3'd0: m_en   = wd[7:0];
        3'd1: m_mask = wd[7:0];
        3'd2: m_prio = wd[23:0];
        3'd3: begin m_mode = wd[0]; m_pol = wd[1]; m_pw = wd[9:2]; end
        3'd5: if (m_claimed && wd[2:0] == m_vec) begin
          exp_clr = 8'h1 << m_vec; m_claimed = 0;
        end else m_err = 1;
        default: ;
      endcase
    end
`ifdef INTC_CLAIM_TIMEOUT_EN
    if (m_claimed && e == m_claim_edge + TO) begin
      exp_clr = 8'h1 << m_vec; m_claimed = 0; m_to = 1;
    end
`endif
  endtask

  initial begin
    int unsigned e, e2;
    logic [31:0] rd, exp_rd;
    logic [7:0]  exp_clr;
    logic        we;
    logic [2:0]  a;
    logic [31:0] wd;

    rst = 1; bus_req = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0;
    irq_pending = 0; irq_vector = 0;
    repeat (3) @(negedge clk);
    check("rst_en", int_enable, 0);
    check("rst_mask", int_mask, 32'hFF);
    check("rst_prio", int_priority, 0);
    check("rst_clr", int_clear, 0);
    check("rst_ack", bus_ack, 0);
    check("rst_rdata", bus_rdata, 0);
    check("rst_mode", out_mode, 0);
    check("rst_pol", out_polarity, 1);
    check("rst_pw", pulse_width, 0);
    check("rst_act", claim_active, 0);
    rst = 0;

    //   we addr  wdata          pend vec rdata          en     mask   prio        clr    act
    row(0, 3'd0, 32'h0,          0, 0, 32'h0,          8'h00, 8'hFF, 24'h0,      8'h00, 0);
    row(0, 3'd1, 32'h0,          0, 0, 32'hFF,         8'h00, 8'hFF, 24'h0,      8'h00, 0);
    row(0, 3'd2, 32'h0,          0, 0, 32'h0,          8'h00, 8'hFF, 24'h0,      8'h00, 0);
    row(0, 3'd3, 32'h0,          0, 0, 32'h2,          8'h00, 8'hFF, 24'h0,      8'h00, 0);
    row(0, 3'd4, 32'h0,          0, 0, 32'h0,          8'h00, 8'hFF, 24'h0,      8'h00, 0);
    row(0, 3'd5, 32'h0,          0, 0, 32'h0,          8'h00, 8'hFF, 24'h0,      8'h00, 0);
    row(0, 3'd6, 32'h0,          0, 0, 32'h0,          8'h00, 8'hFF, 24'h0,      8'h00, 0);
    row(0, 3'd7, 32'h0,          0, 0, 32'h0,          8'h00, 8'hFF, 24'h0,      8'h00, 0);
    row(1, 3'd0, 32'hA5,         0, 0, 32'h0,          8'hA5, 8'hFF, 24'h0,      8'h00, 0);
    row(1, 3'd2, 32'h00FAC688,   0, 0, 32'h0,          8'hA5, 8'hFF, 24'hFAC688, 8'h00, 0);
    row(1, 3'd1, 32'h0F,         0, 0, 32'h0,          8'hA5, 8'h0F, 24'hFAC688, 8'h00, 0);
    row(0, 3'd4, 32'h0,          1, 5, 32'h80000005,   8'hA5, 8'h2F, 24'hFAC688, 8'h00, 1);
    row(0, 3'd4, 32'h0,          1, 5, 32'h0,          8'hA5, 8'h2F, 24'hFAC688, 8'h00, 1);
    row(1, 3'd5, 32'h3,          0, 0, 32'h0,          8'hA5, 8'h2F, 24'hFAC688, 8'h00, 1);
    row(0, 3'd6, 32'h0,          0, 0, 32'h80000020,   8'hA5, 8'h2F, 24'hFAC688, 8'h00, 1);
    row(0, 3'd6, 32'h0,          0, 0, 32'h00000020,   8'hA5, 8'h2F, 24'hFAC688, 8'h00, 1);
    row(1, 3'd5, 32'h5,          0, 0, 32'h0,          8'hA5, 8'h0F, 24'hFAC688, 8'h20, 0);
    row(1, 3'd5, 32'h5,          0, 0, 32'h0,          8'hA5, 8'h0F, 24'hFAC688, 8'h00, 0);
    row(0, 3'd6, 32'h0,          0, 0, 32'h80000000,   8'hA5, 8'h0F, 24'hFAC688, 8'h00, 0);
    row(0, 3'd6, 32'h0,          0, 0, 32'h0,          8'hA5, 8'h0F, 24'hFAC688, 8'h00, 0);
    row(1, 3'd3, 32'hFFFFF2AD,   0, 0, 32'h0,          8'hA5, 8'h0F, 24'hFAC688, 8'h00, 0);
    row(0, 3'd3, 32'h0,          0, 0, 32'h2AD,        8'hA5, 8'h0F, 24'hFAC688, 8'h00, 0);
    row(1, 3'd7, 32'hFFFFFFFF,   0, 0, 32'h0,          8'hA5, 8'h0F, 24'hFAC688, 8'h00, 0);
    row(1, 3'd6, 32'hFFFFFFFF,   0, 0, 32'h0,          8'hA5, 8'h0F, 24'hFAC688, 8'h00, 0);
    row(1, 3'd4, 32'hFFFFFFFF,   1, 2, 32'h0,          8'hA5, 8'h0F, 24'hFAC688, 8'h00, 0);
    row(0, 3'd6, 32'h0,          0, 0, 32'h0,          8'hA5, 8'h0F, 24'hFAC688, 8'h00, 0);
    row(1, 3'd0, 32'hFFFFFF5A,   0, 0, 32'h0,          8'h5A, 8'h0F, 24'hFAC688, 8'h00, 0);
    row(0, 3'd0, 32'h0,          0, 0, 32'h5A,         8'h5A, 8'h0F, 24'hFAC688, 8'h00, 0);

    foreach (tbl[i]) begin
      irq_pending = tbl[i].pend;
      irq_vector  = tbl[i].vec;
      access(tbl[i].we, tbl[i].addr, tbl[i].wdata, e, rd);
      check($sformatf("r%0d_rdata", i), rd, tbl[i].rdata);
      check($sformatf("r%0d_en", i), int_enable, tbl[i].en);
      check($sformatf("r%0d_mask", i), int_mask, tbl[i].mask);
      check($sformatf("r%0d_prio", i), int_priority, tbl[i].prio);
      check($sformatf("r%0d_clr", i), int_clear, tbl[i].clr);
      check($sformatf("r%0d_act", i), claim_active, tbl[i].act);
    end
    irq_pending = 0;
    check("ctrl_mode", out_mode, 1);
    check("ctrl_pol", out_polarity, 0);
    check("ctrl_pw", pulse_width, 32'hAB);
    @(negedge clk);
    check("idle_rdata", bus_rdata, 0);

    // Claim vector 2 and leave it alone.
    irq_pending = 1; irq_vector = 2;
    access(0, ADDR_CLAIM, 0, e, rd);
    irq_pending = 0;
    check("to_claim", rd, 32'h80000002);
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
`ifdef INTC_CLAIM_TIMEOUT_EN
      check($sformatf("to_clr_c%0d", k), int_clear, (k == TO) ? 32'h04 : 32'h0);
      check($sformatf("to_act_c%0d", k), claim_active, (k < TO) ? 32'h1 : 32'h0);
`else
      check($sformatf("to_clr_c%0d", k), int_clear, 0);
      check($sformatf("to_act_c%0d", k), claim_active, 1);
`endif
    end
    access(0, ADDR_INSERVICE, 0, e, rd);
`ifdef INTC_CLAIM_TIMEOUT_EN
    check("to_inservice", rd, 32'h40000000);
    // A valid COMPLETE on the exact timeout edge wins; timeout stays clear.
    irq_pending = 1; irq_vector = 3;
    access(0, ADDR_CLAIM, 0, e, rd);
    irq_pending = 0;
    check("prec_claim", rd, 32'h80000003);
    while (cyc < e + TO - 1) @(negedge clk);
    access(1, ADDR_COMPLETE, 32'h3, e2, rd);
    check("prec_clr", int_clear, 32'h08);
    check("prec_act", claim_active, 0);
`else
    check("to_inservice", rd, 32'h00000004);
    access(1, ADDR_COMPLETE, 32'h2, e2, rd);
    check("cmp_clr", int_clear, 32'h04);
    check("cmp_act", claim_active, 0);
`endif
    @(negedge clk);
    check("pulse_end_clr", int_clear, 0);
    check("pulse_end_ack", bus_ack, 0);
    access(0, ADDR_INSERVICE, 0, e, rd);
    check("post_inservice", rd, 0);

    // Reset in the ACK cycle of a CLAIM read.
    irq_pending = 1; irq_vector = 6;
    @(negedge clk);
    bus_req = 1; bus_we = 0; bus_addr = ADDR_CLAIM; bus_wdata = 0;
    @(negedge clk);
    check("rr_ack", bus_ack, 1);
    check("rr_rdata", bus_rdata, 32'h80000006);
    rst = 1; bus_req = 0;
    #1;
    check("rr_act", claim_active, 0);
    check("rr_ack0", bus_ack, 0);
    check("rr_rdata0", bus_rdata, 0);
    check("rr_en", int_enable, 0);
    check("rr_mask", int_mask, 32'hFF);
    check("rr_prio", int_priority, 0);
    check("rr_ctrl", {out_mode, out_polarity, pulse_width}, 32'h100);
    check("rr_clr", int_clear, 0);
    repeat (2) @(negedge clk);
    rst = 0; irq_pending = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rr_noack%0d", k), bus_ack, 0);
    end

    // Random accesses against the reference model.
    model_reset();
    for (int it = 0; it < 250; it++) begin
      a  = 3'($urandom_range(0, 7));
      we = (a == ADDR_COMPLETE) ? 1'b1 : 1'($urandom_range(0, 1));
      wd = $urandom;
      if (a == ADDR_COMPLETE && $urandom_range(0, 1) == 1) wd[2:0] = m_vec;
      irq_pending = 1'($urandom_range(0, 1));
      irq_vector  = 3'($urandom_range(0, 7));
      access(we, a, wd, e, rd);
      model_step(e, we, a, wd, irq_pending, irq_vector, exp_rd, exp_clr);
      check($sformatf("rnd%0d_rdata", it), rd, exp_rd);
      check($sformatf("rnd%0d_clr", it), int_clear, exp_clr);
      check($sformatf("rnd%0d_act", it), claim_active, m_claimed);
      check($sformatf("rnd%0d_mask", it), int_mask, m_mask | (m_claimed ? (8'h1 << m_vec) : 8'h0));
      check($sformatf("rnd%0d_en", it), int_enable, m_en);
      check($sformatf("rnd%0d_prio", it), int_priority, m_prio);
      check($sformatf("rnd%0d_ctrl", it), {out_mode, out_polarity, pulse_width}, {m_mode, m_pol, m_pw});
      if ($urandom_range(0, 7) == 0) repeat (20) @(negedge clk);
      else repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
